// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter that time-shares one external floating-point multiplier
// between N_REQ valid/ready requesters, one operation in flight at a time.
module fp_mul_arbiter #(
    parameter int N_REQ       = 4,
    parameter int NB_MANTISSA = 8,
    parameter int NB_EXPONENT = 4,
    parameter int NB_DATA     = NB_MANTISSA + NB_EXPONENT + 1,
    parameter int NB_ID       = $clog2(N_REQ),
    parameter int MUL_LATENCY = 1
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ*NB_DATA-1:0] i_req_data_1,
    input  logic [N_REQ*NB_DATA-1:0] i_req_data_2,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic [NB_DATA-1:0]       o_mul_data_1,
    output logic [NB_DATA-1:0]       o_mul_data_2,
    input  logic [NB_DATA-1:0]       i_mul_data,
    input  logic                     i_mul_overflow,
    input  logic                     i_mul_underflow,
    output logic                     o_rsp_valid,
    output logic [NB_ID-1:0]         o_rsp_id,
    output logic [NB_DATA-1:0]       o_rsp_data,
    output logic                     o_rsp_overflow,
    output logic                     o_rsp_underflow,
    input  logic                     i_rsp_ready,
    output logic                     o_busy
);

    localparam int          NB_LAT  = $clog2(MUL_LATENCY + 1);
    localparam int unsigned N_REQ_U = N_REQ;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [NB_ID-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NB_LAT-1:0]  lat_cnt_q, lat_cnt_d;
    logic [NB_ID-1:0]   id_q, id_d;
    logic [NB_DATA-1:0] mul_data_1_q, mul_data_1_d;
    logic [NB_DATA-1:0] mul_data_2_q, mul_data_2_d;
    logic [NB_ID-1:0]   rsp_id_q, rsp_id_d;
    logic [NB_DATA-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_overflow_q, rsp_overflow_d;
    logic               rsp_underflow_q, rsp_underflow_d;

    logic               grant_found;
    logic [NB_ID-1:0]   grant_id;
    logic               accept;

    function automatic logic [NB_ID-1:0] wrap_idx(input logic [NB_ID-1:0] base,
                                                  input int unsigned      off);
        return NB_ID'((32'(base) + off) % N_REQ_U);
    endfunction

    // Search upward from rr_ptr; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int unsigned i = 0; i < N_REQ_U; i++) begin
            if (!grant_found && i_req_valid[wrap_idx(rr_ptr_q, i)]) begin
                grant_found = 1'b1;
                grant_id    = wrap_idx(rr_ptr_q, i);
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (state_q == ST_IDLE && grant_found) begin
            o_req_ready[grant_id] = 1'b1;
        end
    end

    assign accept = |(i_req_valid & o_req_ready);

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        lat_cnt_d       = lat_cnt_q;
        id_d            = id_q;
        mul_data_1_d    = mul_data_1_q;
        mul_data_2_d    = mul_data_2_q;
        rsp_id_d        = rsp_id_q;
        rsp_data_d      = rsp_data_q;
        rsp_overflow_d  = rsp_overflow_q;
        rsp_underflow_d = rsp_underflow_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mul_data_1_d = i_req_data_1[grant_id*NB_DATA +: NB_DATA];
                    mul_data_2_d = i_req_data_2[grant_id*NB_DATA +: NB_DATA];
                    id_d         = grant_id;
                    rr_ptr_d     = wrap_idx(grant_id, 1);
                    lat_cnt_d    = NB_LAT'(MUL_LATENCY);
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                lat_cnt_d = lat_cnt_q - 1'b1;
                if (lat_cnt_q == NB_LAT'(1)) begin
                    rsp_data_d      = i_mul_data;
                    rsp_overflow_d  = i_mul_overflow;
                    rsp_underflow_d = i_mul_underflow;
                    rsp_id_d        = id_q;
                    state_d         = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q         <= ST_IDLE;
            rr_ptr_q        <= '0;
            lat_cnt_q       <= '0;
            id_q            <= '0;
            mul_data_1_q    <= '0;
            mul_data_2_q    <= '0;
            rsp_id_q        <= '0;
            rsp_data_q      <= '0;
            rsp_overflow_q  <= 1'b0;
            rsp_underflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            lat_cnt_q       <= lat_cnt_d;
            id_q            <= id_d;
            mul_data_1_q    <= mul_data_1_d;
            mul_data_2_q    <= mul_data_2_d;
            rsp_id_q        <= rsp_id_d;
            rsp_data_q      <= rsp_data_d;
            rsp_overflow_q  <= rsp_overflow_d;
            rsp_underflow_q <= rsp_underflow_d;
        end
    end

    assign o_mul_data_1    = mul_data_1_q;
    assign o_mul_data_2    = mul_data_2_q;
    assign o_rsp_valid     = (state_q == ST_RESP);
    assign o_rsp_id        = rsp_id_q;
    assign o_rsp_data      = rsp_data_q;
    assign o_rsp_overflow  = rsp_overflow_q;
    assign o_rsp_underflow = rsp_underflow_q;
    assign o_busy          = (state_q != ST_IDLE);

endmodule
